// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 access codes,
// FSM state encoding and the funct3 legality helper.
package data_mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Unsigned load codes have no store counterpart; 011/110/111 are never legal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// M-stage memory access port between the core (master) and the data memory (slave).
interface data_mem_ctrl_if;
    logic        MemReqM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] AddrM;
    logic [31:0] WrDataM;
    logic [31:0] ReadData;
    logic        MemBusy;
    logic        AccessErr;

    modport master (
        output MemReqM, MemWriteM, funct3M, AddrM, WrDataM,
        input  ReadData, MemBusy, AccessErr
    );

    modport slave (
        input  MemReqM, MemWriteM, funct3M, AddrM, WrDataM,
        output ReadData, MemBusy, AccessErr
    );
endinterface

// File: rtl/data_mem_ctrl_ls_align.sv
// Combinational RV32I load/store lane alignment: byte enables and lane-replicated
// store data, extended load result, and the access-error flag.
module ls_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic        err,
    output logic [31:0] rext
);

    logic        misaligned_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword out of the RAM word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = rword[7:0];
            2'd1:    byte_s = rword[15:8];
            2'd2:    byte_s = rword[23:16];
            2'd3:    byte_s = rword[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rword[31:16];
        end else begin
            half_s = rword[15:0];
        end
    end

    // Decode size: lane enables, replicated store data, extension and alignment.
    always_comb begin
        be           = 4'b0000;
        wlane        = 32'h0000_0000;
        rext         = 32'h0000_0000;
        misaligned_s = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr_lo;
                wlane = {4{wdata[7:0]}};
                if (funct3 == F3_B) begin
                    rext = {{24{byte_s[7]}}, byte_s};
                end else begin
                    rext = {24'h00_0000, byte_s};
                end
            end
            F3_H, F3_HU: begin
                misaligned_s = addr_lo[0];
                be           = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlane        = {2{wdata[15:0]}};
                if (funct3 == F3_H) begin
                    rext = {{16{half_s[15]}}, half_s};
                end else begin
                    rext = {16'h0000, half_s};
                end
            end
            F3_W: begin
                misaligned_s = (addr_lo != 2'd0);
                be           = 4'b1111;
                wlane        = wdata;
                rext         = rword;
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

    assign err = misaligned_s | ~f3_legal(funct3, we);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the M-stage access port: request latch, wait-state
// counter, IDLE/WAIT/ACCESS/DONE FSM and a word-wide RAM with per-byte writes.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_ctrl_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [3:0]            cnt_r;
    logic [ADDR_W+1:0]     addr_r;
    logic [31:0]           wdata_r;
    logic [2:0]            funct3_r;
    logic                  we_r;
    logic [31:0]           read_data_r;
    logic                  access_err_r;
    logic                  busy_s;
    logic                  ram_we_s;
    logic [3:0]            be_s;
    logic [31:0]           wlane_s;
    logic                  err_s;
    logic [31:0]           rext_s;
    logic [31:0]           rword_s;
    logic [ADDR_W-1:0]     idx_s;
    logic [31:0]           mem_r [DEPTH];

    // Address bits above the RAM index wrap away by design.
    logic addr_hi_unused_s;
    assign addr_hi_unused_s = ^bus.AddrM[31:ADDR_W+2];

    assign idx_s   = addr_r[ADDR_W+1:2];
    assign rword_s = mem_r[idx_s];

    ls_align u_ls_align (
        .funct3  (funct3_r),
        .we      (we_r),
        .addr_lo (addr_r[1:0]),
        .wdata   (wdata_r),
        .rword   (rword_s),
        .be      (be_s),
        .wlane   (wlane_s),
        .err     (err_s),
        .rext    (rext_s)
    );

    // Next-state decode and pipeline stall request.
    always_comb begin
        state_nxt_s = state_r;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.MemReqM) begin
                    busy_s      = 1'b1;
                    state_nxt_s = (WAIT_STATES == 32'd0) ? ST_ACCESS : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                busy_s = 1'b1;
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                busy_s      = 1'b1;
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, request latches, wait counter and registered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            addr_r       <= '0;
            wdata_r      <= 32'h0000_0000;
            funct3_r     <= 3'b000;
            we_r         <= 1'b0;
            read_data_r  <= 32'h0000_0000;
            access_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.MemReqM) begin
                        addr_r   <= bus.AddrM[ADDR_W+1:0];
                        wdata_r  <= bus.WrDataM;
                        funct3_r <= bus.funct3M;
                        we_r     <= bus.MemWriteM;
                        cnt_r    <= 4'(WAIT_STATES);
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                end
                ST_ACCESS: begin
                    read_data_r  <= (we_r | err_s) ? 32'h0000_0000 : rext_s;
                    access_err_r <= err_s;
                end
                ST_DONE: begin
                    access_err_r <= 1'b0;
                end
                default: begin
                    access_err_r <= 1'b0;
                end
            endcase
        end
    end

    // A store commits only at the closing edge of ACCESS, and never on error.
    assign ram_we_s = reset & (state_r == ST_ACCESS) & we_r & ~err_s;

    // RAM array with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.MemBusy   = reset & busy_s;
    assign bus.ReadData  = read_data_r;
    assign bus.AccessErr = access_err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: directed vector table, reset/wrap corner sequences and
// randomized accesses against a byte-array reference model.
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  req_d;
    logic [1:0]  we_d;
    logic [2:0]  f3_d   [2];
    logic [31:0] addr_d [2];
    logic [31:0] wd_d   [2];
    logic        busy_o;
    logic        err_o;
    logic [31:0] rdata_o;

    int n_checks;
    int n_fail;

    byte unsigned mem_m [4096];

    data_mem_ctrl_if bus0 ();
    data_mem_ctrl_if bus1 ();

    assign bus0.MemReqM   = req_d[0];
    assign bus0.MemWriteM = we_d[0];
    assign bus0.funct3M   = f3_d[0];
    assign bus0.AddrM     = addr_d[0];
    assign bus0.WrDataM   = wd_d[0];
    assign bus1.MemReqM   = req_d[1];
    assign bus1.MemWriteM = we_d[1];
    assign bus1.funct3M   = f3_d[1];
    assign bus1.AddrM     = addr_d[1];
    assign bus1.WrDataM   = wd_d[1];

    assign busy_o  = sel ? bus1.MemBusy   : bus0.MemBusy;
    assign err_o   = sel ? bus1.AccessErr : bus0.AccessErr;
    assign rdata_o = sel ? bus1.ReadData  : bus0.ReadData;

    data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .bus(bus0));
    data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit [2:0]    f3;
        bit [31:0]   addr;
        bit [31:0]   wdata;
        bit [31:0]   exp_rd;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access on the selected DUT; the request is left asserted afterwards.
    task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic er, output int nb);
        bit done;
        nb = 0; done = 1'b0; rd = 32'h0; er = 1'b0;
        @(negedge clk);
        req_d[sel] = 1'b1; we_d[sel] = we; f3_d[sel] = f3;
        addr_d[sel] = a; wd_d[sel] = wd;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (busy_o) begin
                nb++;
                @(negedge clk);
            end else begin
                rd = rdata_o; er = err_o; done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: MemBusy still 1 after 20 cycles, required 0");
        end
    endtask

    task automatic run(input string name, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd; logic er; int nb;
        do_access(we, f3, a, wd, rd, er, nb);
        chk({name, ".rdata"}, rd, exp_rd);
        chk({name, ".err"}, {31'd0, er}, {31'd0, exp_err});
        chk({name, ".busy"}, nb, sel ? 32'd3 : 32'd2);
    endtask

    // Reference: access rules applied to a flat byte memory.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output bit er);
        int     size;
        int     base;
        bit     is_signed;
        longint v;
        size      = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        is_signed = !f3[2];
        er = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) ||
             (size == 2 && a % 2 != 0) || (size == 4 && a % 4 != 0);
        rd = 32'h0;
        if (!er) begin
            base = int'(a % 4096);
            if (we) begin
                for (int i = 0; i < size; i++) mem_m[base + i] = byte'(wd >> (8 * i));
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v + (longint'(mem_m[base + i]) << (8 * i));
                if (is_signed && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                rd = v[31:0];
            end
        end
    endtask

    vec_t vecs [$];

    initial begin
        logic [31:0] erd; bit eer; logic [2:0] f3; bit we; logic [31:0] a, wd;
        n_checks = 0; n_fail = 0;
        sel = 1'b1; reset = 1'b0;
        req_d = 2'b11; we_d = 2'b00;
        for (int i = 0; i < 2; i++) begin f3_d[i] = 3'd2; addr_d[i] = 32'h0; wd_d[i] = 32'h0; end

        // Reset state: MemBusy forced low even with a request present.
        #12;
        chk("rst.busy1", {31'd0, bus1.MemBusy}, 32'd0);
        chk("rst.busy0", {31'd0, bus0.MemBusy}, 32'd0);
        chk("rst.rdata", bus1.ReadData, 32'h0);
        chk("rst.err",   {31'd0, bus1.AccessErr}, 32'd0);
        req_d = 2'b00;
        @(negedge clk); reset = 1'b1;

        vecs = '{
            '{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0},
            '{0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0},
            '{1, 3'd0, 32'h11, 32'h0000007F, 32'h0,        0},
            '{0, 3'd2, 32'h10, 32'h0,        32'hDEAD7FEF, 0},
            '{0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 0},
            '{0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 0},
            '{1, 3'd1, 32'h12, 32'h00008001, 32'h0,        0},
            '{0, 3'd1, 32'h12, 32'h0,        32'hFFFF8001, 0},
            '{0, 3'd5, 32'h12, 32'h0,        32'h00008001, 0},
            '{0, 3'd2, 32'h10, 32'h0,        32'h80017FEF, 0},
            '{0, 3'd2, 32'h12, 32'h0,        32'h0,        1},
            '{1, 3'd1, 32'h13, 32'h0000FFFF, 32'h0,        1},
            '{1, 3'd4, 32'h10, 32'h00000055, 32'h0,        1},
            '{0, 3'd3, 32'h10, 32'h0,        32'h0,        1},
            '{0, 3'd2, 32'h10, 32'h0,        32'h80017FEF, 0},
            '{1, 3'd2, 32'h20, 32'h11111111, 32'h0,        0}
        };
        foreach (vecs[i])
            run($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);

        // Reset during WAIT drops the pending store.
        @(negedge clk);
        req_d[1] = 1'b1; we_d[1] = 1'b1; f3_d[1] = 3'd2; addr_d[1] = 32'h20; wd_d[1] = 32'h12345678;
        @(negedge clk);
        #1 chk("midrst.busy_before", {31'd0, bus1.MemBusy}, 32'd1);
        reset = 1'b0;
        #1 chk("midrst.busy", {31'd0, bus1.MemBusy}, 32'd0);
        chk("midrst.rdata", bus1.ReadData, 32'h0);
        req_d[1] = 1'b0;
        @(negedge clk); reset = 1'b1;
        run("midrst.lw", 0, 3'd2, 32'h20, 32'h0, 32'h11111111, 0);

        // Randomized accesses over a 16-word region, upper address bits random.
        for (int w = 0; w < 16; w++) begin
            a = 32'h100 + 32'(4 * w); wd = $urandom;
            model(1'b1, 3'd2, a, wd, erd, eer);
            run("fill", 1'b1, 3'd2, a, wd, erd, eer);
        end
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end else begin
                case ($urandom_range(0, 2))
                    0: f3 = 3'd3; 1: f3 = 3'd6; default: f3 = 3'd7;
                endcase
            end
            we = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 63));
            wd = $urandom;
            model(we, f3, a, wd, erd, eer);
            run($sformatf("rnd%0d", n), we, f3, a, wd, erd, eer);
        end
        @(negedge clk); req_d[1] = 1'b0;

        // Zero wait states: back-to-back store/load across the wrap boundary.
        sel = 1'b0;
        run("ws0.sw", 1, 3'd2, 32'h1000, 32'hA5A5A5A5, 32'h0, 0);
        run("ws0.lw", 0, 3'd2, 32'h0, 32'h0, 32'hA5A5A5A5, 0);
        @(negedge clk);
        req_d[0] = 1'b0;
        #1 chk("ws0.no_reaccept", {31'd0, bus0.MemBusy}, 32'd0);
        chk("ws0.hold", bus0.ReadData, 32'hA5A5A5A5);
        @(negedge clk);
        chk("ws0.hold2", bus0.ReadData, 32'hA5A5A5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
